// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style memory interface and fetch stage.
//   START_ADDR   : PC after reset (memory base)
//   SZ_*         : memory access-size encodings (words per request)
//   RW_*         : memory read/write select
//   WORD_BYTES   : bytes per instruction word
//   fetch_state_t: issue-control FSM states
package mips_pkg;

  localparam logic [31:0] START_ADDR = 32'h8002_0000;

  localparam logic [1:0] SZ_1W  = 2'b00;
  localparam logic [1:0] SZ_4W  = 2'b01;
  localparam logic [1:0] SZ_8W  = 2'b10;
  localparam logic [1:0] SZ_16W = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int unsigned WORD_BYTES = 4;

  // IDLE: no request outstanding; WAIT: one request outstanding.
  typedef enum logic {
    FETCH_IDLE,
    FETCH_WAIT
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, insn} entries.
//   clock, reset : clock, asynchronous active-high reset
//   push/push_data : write an entry at the tail
//   pop          : drop the head entry
//   flush        : empty the queue (wins over push and pop)
//   head         : current head entry (stale when count is zero)
//   count        : number of valid entries
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;

  assign full = (count == CW'(DEPTH));
  assign head = slots[rd_ptr];

  always_ff @(posedge clock) begin
    if (push && !flush) begin
      slots[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_push_when_full: assert property (@(posedge clock) disable iff (reset)
    !(push && full && !flush));
  a_no_pop_when_empty: assert property (@(posedge clock) disable iff (reset)
    !(pop && (count == '0) && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage in front of byte-addressed main memory.
// Issues single-word reads at the PC, queues returned words and hands
// {pc, insn} to decode with a valid/stall handshake. A redirect loads a
// new PC and flushes queued and outstanding fetches.
//   clock, reset        : clock, asynchronous active-high reset
//   stall               : decode cannot accept this cycle
//   redirect_valid/_pc  : load new PC (low two bits forced to zero), flush
//   mem_address/_access_size/_rw/_enable : read request to memory
//   mem_busy            : memory cannot accept a request this cycle
//   mem_data_in         : read data, valid the cycle after the request
//   insn_valid/insn_out/pc_out : head instruction presented to decode
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR  = mips_pkg::START_ADDR,
  parameter int unsigned           QUEUE_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [1:0]            mem_access_size,
  output logic                  mem_rw,
  output logic                  mem_enable,
  input  logic                  mem_busy,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  insn_valid,
  output logic [DATA_WIDTH-1:0] insn_out,
  output logic [ADDR_WIDTH-1:0] pc_out
);

  import mips_pkg::*;

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned EW = ADDR_WIDTH + DATA_WIDTH;

  fetch_state_t          state;
  fetch_state_t          state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] issue_pc;
  logic [ADDR_WIDTH-1:0] last_pc;
  logic [DATA_WIDTH-1:0] last_insn;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic [DATA_WIDTH-1:0] head_insn;
  logic [EW-1:0]         head;
  logic [CW-1:0]         count;
  logic [CW-1:0]         slots_claimed;
  logic                  pop;
  logic                  push;
  logic                  issue;

  assign insn_valid         = (count != '0);
  assign pop                = insn_valid && !stall;
  assign {head_pc, head_insn} = head;
  // Outputs hold the last presented entry while the queue is empty.
  assign pc_out             = insn_valid ? head_pc   : last_pc;
  assign insn_out           = insn_valid ? head_insn : last_insn;

  assign mem_address        = pc;
  assign mem_access_size    = SZ_1W;
  assign mem_rw             = RW_READ;
  assign mem_enable         = issue;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= FETCH_IDLE;
    else       state <= state_next;
  end

  // Issue is blocked in a redirect cycle, so the only response that can be
  // outstanding then lands in that same cycle and is dropped by gating
  // push; nothing stale can arrive afterwards, hence no squash flag.
  always_comb begin
    issue         = 1'b0;
    push          = 1'b0;
    state_next    = state;
    slots_claimed = count - CW'(pop) + CW'(state == FETCH_WAIT);
    if (!reset && !mem_busy && !redirect_valid &&
        (slots_claimed < CW'(QUEUE_DEPTH))) begin
      issue = 1'b1;
    end
    case (state)
      FETCH_IDLE: begin
        if (issue) state_next = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        push       = !redirect_valid;
        state_next = issue ? FETCH_WAIT : FETCH_IDLE;
      end
      default: state_next = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc        <= START_ADDR;
      issue_pc  <= START_ADDR;
      last_pc   <= START_ADDR;
      last_insn <= '0;
    end else begin
      if (redirect_valid) begin
        pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      end else if (issue) begin
        pc       <= pc + ADDR_WIDTH'(WORD_BYTES);
        issue_pc <= pc;
      end
      if (insn_valid) begin
        last_pc   <= head_pc;
        last_insn <= head_insn;
      end
    end
  end

  fetch_queue #(
    .WIDTH(EW),
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data ({issue_pc, mem_data_in}),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] START = 32'h8002_0000;
  localparam int          QD    = 2;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mem_address;
  logic [1:0]  mem_access_size;
  logic        mem_rw;
  logic        mem_enable;
  logic        mem_busy;
  logic [31:0] mem_data_in;
  logic        insn_valid;
  logic [31:0] insn_out;
  logic [31:0] pc_out;

  fetch_unit #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .START_ADDR (START),
    .QUEUE_DEPTH(QD)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_address    (mem_address),
    .mem_access_size(mem_access_size),
    .mem_rw         (mem_rw),
    .mem_enable     (mem_enable),
    .mem_busy       (mem_busy),
    .mem_data_in    (mem_data_in),
    .insn_valid     (insn_valid),
    .insn_out       (insn_out),
    .pc_out         (pc_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory contents: three preloaded words, everything else address-derived.
  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h8002_0000: return 32'h2401_0001;
      32'h8002_0004: return 32'h2402_0002;
      32'h8002_0008: return 32'h2403_0003;
      default:       return a ^ 32'h5A5A_A5A5;
    endcase
  endfunction

  // One-cycle read latency memory.
  logic        rsp_valid;
  logic [31:0] rsp_addr;
  always @(posedge clock) begin
    rsp_valid <= mem_enable;
    rsp_addr  <= mem_address;
  end
  assign mem_data_in = rsp_valid ? word(rsp_addr) : 32'hDEAD_BEEF;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Reference model: queue of delivered pcs, one outstanding request, next pc.
  logic [31:0] mq[$];
  bit          m_inflight;
  logic [31:0] m_ipc;
  logic [31:0] m_pc;
  logic [31:0] m_last_pc;
  logic [31:0] m_last_insn;

  task automatic model_reset();
    mq.delete();
    m_inflight  = 1'b0;
    m_ipc       = START;
    m_pc        = START;
    m_last_pc   = START;
    m_last_insn = '0;
  endtask

  // Called mid-cycle with inputs stable: compare, then advance past the edge.
  task automatic model_step();
    bit pop;
    bit en;
    int occ;
    if (reset) begin
      check("rst_valid", insn_valid, 1'b0);
      check("rst_en",    mem_enable, 1'b0);
      check("rst_pc",    pc_out,     START);
      check("rst_insn",  insn_out,   32'h0);
      model_reset();
      return;
    end
    check("valid", insn_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("pc_out",   pc_out,   mq[0]);
      check("insn_out", insn_out, word(mq[0]));
    end else begin
      check("hold_pc",   pc_out,   m_last_pc);
      check("hold_insn", insn_out, m_last_insn);
    end
    pop = (mq.size() != 0) && !stall;
    occ = mq.size() - int'(pop) + int'(m_inflight);
    en  = !mem_busy && !redirect_valid && (occ < QD);
    check("mem_enable", mem_enable, en);
    if (en) check("mem_address", mem_address, m_pc);
    if (mq.size() != 0) begin
      m_last_pc   = mq[0];
      m_last_insn = word(mq[0]);
    end
    if (redirect_valid) begin
      mq.delete();
      m_inflight = 1'b0;
      m_pc       = redirect_pc & ~32'h3;
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_inflight) mq.push_back(m_ipc);
      m_inflight = en;
      if (en) begin
        m_ipc = m_pc;
        m_pc  = m_pc + 32'd4;
      end
    end
  endtask

  task automatic end_cycle();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic cycle();
    @(negedge clock);
    end_cycle();
  endtask

  task automatic idle_inputs();
    stall          = 1'b0;
    mem_busy       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_inputs();
    model_reset();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  typedef struct {
    bit          rst;
    bit          stall;
    bit          en;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
    logic [31:0] insn;
  } vec_t;

  vec_t tbl[16];

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();

    // Startup stream, then stall-after-first-valid scenario.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 32'h8002_0000, 1'b0, START,         32'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'h8002_0004, 1'b0, START,         32'h0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'h8002_0008, 1'b1, 32'h8002_0000, 32'h2401_0001};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'h8002_000C, 1'b1, 32'h8002_0004, 32'h2402_0002};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h8002_0010, 1'b1, 32'h8002_0008, 32'h2403_0003};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'h8002_0000, 1'b0, START,         32'h0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h8002_0004, 1'b0, START,         32'h0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8002_0000, 32'h2401_0001};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8002_0000, 32'h2401_0001};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8002_0000, 32'h2401_0001};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8002_0000, 32'h2401_0001};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8002_0000, 32'h2401_0001};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 32'h8002_0008, 1'b1, 32'h8002_0000, 32'h2401_0001};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 32'h8002_000C, 1'b1, 32'h8002_0004, 32'h2402_0002};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 32'h8002_0010, 1'b1, 32'h8002_0008, 32'h2403_0003};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 32'h8002_0014, 1'b1, 32'h8002_000C, 32'hDA58_A5A9};

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].rst) apply_reset();
      stall = tbl[i].stall;
      @(negedge clock);
      check("tbl_en", mem_enable, tbl[i].en);
      if (tbl[i].en) check("tbl_addr", mem_address, tbl[i].addr);
      check("tbl_valid", insn_valid, tbl[i].valid);
      check("tbl_pc",    pc_out,     tbl[i].pc);
      check("tbl_insn",  insn_out,   tbl[i].insn);
      end_cycle();
    end
    check("access_size", mem_access_size, 2'b00);
    check("rw",          mem_rw,          1'b1);

    // Redirect while a fetch is outstanding.
    apply_reset();
    repeat (3) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8002_0043;
    @(negedge clock);
    check("redir_no_issue", mem_enable, 1'b0);
    end_cycle();
    redirect_valid = 1'b0;
    @(negedge clock);
    check("redir_issue_en",   mem_enable,  1'b1);
    check("redir_issue_addr", mem_address, 32'h8002_0040);
    check("redir_flushed",    insn_valid,  1'b0);
    end_cycle();
    cycle();
    @(negedge clock);
    check("redir_valid", insn_valid, 1'b1);
    check("redir_pc",    pc_out,     32'h8002_0040);
    end_cycle();

    // Memory busy for three cycles mid-stream.
    apply_reset();
    repeat (4) cycle();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("busy_no_issue", mem_enable, 1'b0);
      end_cycle();
    end
    mem_busy = 1'b0;
    @(negedge clock);
    check("busy_resume_addr", mem_address, 32'h8002_0010);
    end_cycle();
    repeat (4) cycle();

    // Asynchronous reset in the middle of a burst.
    apply_reset();
    repeat (5) cycle();
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", insn_valid, 1'b0);
    check("async_rst_en",    mem_enable, 1'b0);
    model_reset();
    cycle();
    cycle();
    reset = 1'b0;
    @(negedge clock);
    check("restart_en",   mem_enable,  1'b1);
    check("restart_addr", mem_address, START);
    end_cycle();
    repeat (4) cycle();

    // Redirect to the top of the address space (during stall) and wrap.
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clock);
    check("wrap_addr0", mem_address, 32'hFFFF_FFFC);
    end_cycle();
    @(negedge clock);
    check("wrap_addr1", mem_address, 32'h0000_0000);
    end_cycle();
    @(negedge clock);
    check("wrap_pc0", pc_out, 32'hFFFF_FFFC);
    end_cycle();
    @(negedge clock);
    check("wrap_pc1", pc_out, 32'h0000_0000);
    end_cycle();

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) apply_reset();
      stall          = ($urandom_range(0, 9) < 3);
      mem_busy       = ($urandom_range(0, 9) < 2);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                   : $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
